// File: rtl/flow_led_gen.sv
// ---------------------------------------------------------------------------
// flow_led_gen -- parametrised flowing-LED pattern generator
//
// A prescaler divides sys_clk into step events, one every CNT_MAX+1 enabled
// cycles. Each step advances an LED_W-bit pattern in one of four modes:
// rotate left, rotate right, bounce, or blink. Changing mode reloads the
// pattern with the seed of the new mode and restarts the prescaler.
//
// Ports:
//   sys_clk    in   1      system clock
//   sys_rst    in   1      synchronous, active-high reset
//   en         in   1      run enable; 0 freezes prescaler and pattern
//   mode       in   2      00 rotate left, 01 rotate right, 10 bounce, 11 blink
//   led_out    out  LED_W  registered LED drive
//   step_tick  out  1      registered strobe, high in the first cycle of a new step value
//   dir        out  1      bounce direction (0 toward MSB, 1 toward LSB), registered
//
// Optional feature macro: FLOW_LED_TRAIL_EN
//   When defined, shift modes (00/01/10) light the current position and the
//   position before the latest step, giving a two-LED trail. Blink is unchanged.
// ---------------------------------------------------------------------------
module flow_led_gen #(
    parameter int LED_W   = 8,
    parameter int CNT_W   = 24,
    parameter int CNT_MAX = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led_out,
    output logic             step_tick,
    output logic             dir
);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

    mode_e            mode_in;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LED_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;

    logic             reload;
    logic             step;
    logic [LED_W-1:0] rol, ror, shl, shr;

    assign mode_in = mode_e'(mode);

    function automatic logic [LED_W-1:0] seed_of(input mode_e m);
        logic [LED_W-1:0] s;
        s = '0;
        case (m)
            MODE_ROR:   s[LED_W-1] = 1'b1;
            MODE_BLINK: s = '1;
            default:    s[0] = 1'b1;
        endcase
        return s;
    endfunction

    // A mode change always wins: it reloads even while disabled and masks any
    // coincident terminal count.
    assign reload = (mode_in != mode_q);
    assign step   = en && !reload && !(cnt_q < CNT_MAX_C);

    // Shift-based rotations degrade to "hold" when LED_W == 1.
    assign rol = (pos_q << 1) | (pos_q >> (LED_W - 1));
    assign ror = (pos_q >> 1) | (pos_q << (LED_W - 1));
    assign shl = pos_q << 1;
    assign shr = pos_q >> 1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the branches below leaves a variable unassigned (no latch).
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        tick_d = 1'b0;

        if (reload) begin
            cnt_d = '0;
            dir_d = 1'b0;
            pos_d = seed_of(mode_in);
        end else if (en) begin
            if (cnt_q < CNT_MAX_C) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (mode_q)
                    MODE_ROL:   pos_d = rol;
                    MODE_ROR:   pos_d = ror;
                    MODE_BLINK: pos_d = ~pos_q;
                    default: begin
                        // Bounce: direction flips on the same edge that
                        // lands on an end LED, so ends are lit for one step.
                        if (LED_W > 1) begin
                            if (!dir_q) begin
                                pos_d = shl;
                                if (shl[LED_W-1]) dir_d = 1'b1;
                            end else begin
                                pos_d = shr;
                                if (shr[0]) dir_d = 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (sys_rst) begin
            cnt_q  <= '0;
            mode_q <= MODE_ROL;
            pos_q  <= LED_W'(1);
            dir_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_in;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
        end
    end

    assign step_tick = tick_q;
    assign dir       = dir_q;

`ifdef FLOW_LED_TRAIL_EN
    logic [LED_W-1:0] prev_q, prev_d;
    logic [LED_W-1:0] led_q, led_d;

    always_comb begin
        prev_d = prev_q;
        if (reload) begin
            prev_d = '0;
        end else if (step && mode_q != MODE_BLINK) begin
            prev_d = pos_q;
        end
        // mode_in is what mode_q holds after this edge.
        led_d = (mode_in == MODE_BLINK) ? pos_d : (pos_d | prev_d);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prev_q <= '0;
            led_q  <= LED_W'(1);
        end else begin
            prev_q <= prev_d;
            led_q  <= led_d;
        end
    end

    assign led_out = led_q;
`else
    assign led_out = pos_q;
`endif

    logic unused_step;
    assign unused_step = step;

endmodule

// File: tb/tb_flow_led_gen.sv
// ---------------------------------------------------------------------------
// tb_flow_led_gen -- directed self-checking bench for flow_led_gen
// (LED_W = 8, CNT_MAX = 2, default build without the trail feature).
// ---------------------------------------------------------------------------
module tb_flow_led_gen;

    localparam int LED_W   = 8;
    localparam int CNT_W   = 24;
    localparam int CNT_MAX = 2;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic             en;
    logic [1:0]       mode;
    logic [LED_W-1:0] led_out;
    logic             step_tick;
    logic             dir;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] cur_led;

    logic [7:0] rol_tbl [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] ror_tbl [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [7:0] bnc_tbl [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic       bnc_dir [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 sys_clk = ~sys_clk;

    flow_led_gen #(
        .LED_W  (LED_W),
        .CNT_W  (CNT_W),
        .CNT_MAX(CNT_MAX)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (en),
        .mode     (mode),
        .led_out  (led_out),
        .step_tick(step_tick),
        .dir      (dir)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample just after the active edge.
    task automatic clk1();
        @(posedge sys_clk);
        #1;
    endtask

    // Two idle cycles (pattern holds, no strobe) then one step cycle.
    task automatic run_step(input string tag, input logic [7:0] exp_led, input logic exp_dir);
        repeat (2) begin
            clk1();
            check({tag, "_idle_tick"}, 32'(step_tick), 32'd0);
            check({tag, "_idle_led"},  32'(led_out),   32'(cur_led));
        end
        clk1();
        check({tag, "_led"},  32'(led_out),   32'(exp_led));
        check({tag, "_tick"}, 32'(step_tick), 32'd1);
        check({tag, "_dir"},  32'(dir),       32'(exp_dir));
        cur_led = exp_led;
    endtask

    initial begin
        sys_rst = 1'b1;
        en      = 1'b1;
        mode    = 2'b00;
        clk1();
        clk1();
        check("rst_led",  32'(led_out),   32'h01);
        check("rst_dir",  32'(dir),       32'd0);
        check("rst_tick", 32'(step_tick), 32'd0);
        cur_led = 8'h01;
        sys_rst = 1'b0;

        // Rotate left through a full wrap.
        for (int i = 0; i < 8; i++) run_step("rol", rol_tbl[i], 1'b0);

        // Freeze with cnt = 1; two enabled cycles needed afterwards.
        clk1();
        check("frz_pre_tick", 32'(step_tick), 32'd0);
        en = 1'b0;
        repeat (5) begin
            clk1();
            check("frz_led",  32'(led_out),   32'h01);
            check("frz_tick", 32'(step_tick), 32'd0);
        end
        en = 1'b1;
        clk1();
        check("frz_resume1_led",  32'(led_out),   32'h01);
        check("frz_resume1_tick", 32'(step_tick), 32'd0);
        clk1();
        check("frz_resume2_led",  32'(led_out),   32'h02);
        check("frz_resume2_tick", 32'(step_tick), 32'd1);

        // Enable low exactly on the terminal cycle suppresses the step.
        clk1();
        clk1();
        en = 1'b0;
        clk1();
        check("term_gated_led",  32'(led_out),   32'h02);
        check("term_gated_tick", 32'(step_tick), 32'd0);
        en = 1'b1;
        clk1();
        check("term_late_led",  32'(led_out),   32'h04);
        check("term_late_tick", 32'(step_tick), 32'd1);

        // Mode change to blink coincident with a terminal count.
        clk1();
        clk1();
        mode = 2'b11;
        clk1();
        check("blink_reload_led",  32'(led_out),   32'hFF);
        check("blink_reload_tick", 32'(step_tick), 32'd0);
        check("blink_reload_dir",  32'(dir),       32'd0);
        cur_led = 8'hFF;
        run_step("blink", 8'h00, 1'b0);
        run_step("blink", 8'hFF, 1'b0);

        // Reset mid-period.
        clk1();
        sys_rst = 1'b1;
        mode    = 2'b00;
        clk1();
        check("midrst_led",  32'(led_out),   32'h01);
        check("midrst_dir",  32'(dir),       32'd0);
        check("midrst_tick", 32'(step_tick), 32'd0);
        sys_rst = 1'b0;
        cur_led = 8'h01;
        run_step("post_rst", 8'h02, 1'b0);

        // Rotate right: reload to MSB seed, then full wrap.
        mode = 2'b01;
        clk1();
        check("ror_reload_led",  32'(led_out),   32'h80);
        check("ror_reload_tick", 32'(step_tick), 32'd0);
        cur_led = 8'h80;
        for (int i = 0; i < 8; i++) run_step("ror", ror_tbl[i], 1'b0);

        // Bounce: full sweep up, down and back up one.
        mode = 2'b10;
        clk1();
        check("bnc_reload_led",  32'(led_out),   32'h01);
        check("bnc_reload_tick", 32'(step_tick), 32'd0);
        check("bnc_reload_dir",  32'(dir),       32'd0);
        cur_led = 8'h01;
        for (int i = 0; i < 15; i++) run_step("bnc", bnc_tbl[i], bnc_dir[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
